load_replay_sched: RTL and testbench
====================================

# load_replay_sched

Central replay scheduler between the load pipelines and the load issue banks. It buffers non-TLB replay requests raised by each load pipeline in a shared entry pool and holds each entry until its wake condition is met. The wake conditions are a fixed delay, or a D-cache refill with a timeout. It then releases at most one entry per bank per cycle back to the owning issue bank, which re-arms that entry for issue. It also applies backpressure to load issue and flushes mis-speculated entries on redirect.

## Interface
- DEPTH, 8: replay pool entries (power of two).
- PIPE, `LOAD_PIPELINE (2): load pipelines. Pipeline/bank i maps 1:1.
- DELAY, 4: wait cycles for store-data replays, 1..15.
- MISS_TIMEOUT, 64: maximum wait for a refill before forced wake, 2..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_en  in  PIPE  replay request per pipeline.
- req_issue_idx  in  PIPE×`LOAD_ISSUE_BANK_WIDTH  issue-bank slot to re-arm.
- req_reason  in  PIPE×2  00 bank conflict, 01 store data not ready, 10 dcache miss, 11 TLB miss.
- req_rob_idx  in  PIPE×RobIdx  age of the load.
- refill_en  in  1  D-cache refill completed this cycle (broadcast).
- backendCtrl  in  BackendCtrl  uses redirect and redirectIdx.
- rel_en  out  PIPE  registered release pulse to bank i.
- rel_idx  out  PIPE×`LOAD_ISSUE_BANK_WIDTH  slot released to bank i.
- full  out  1  free entries < PIPE. Stalls load issue.
- count  out  $clog2(DEPTH)+1  valid entries.
- overflow  out  1  sticky, set when a request is dropped for lack of space.

## Operation
- Each entry holds valid, bank, issue_idx, robIdx, state, and an 8-bit counter.
- Entry states:
  - FREE
  - WAIT_DLY: counter counts down.
  - WAIT_RFL: waiting for a refill, counter counts down as the timeout.
  - READY
- Reason 11 requests are ignored. The issue bank handles TLB misses itself. No entry is allocated and overflow is not set.
- Allocation:
  - Pipe 0 takes the lowest FREE slot. Pipe 1 takes the next lowest FREE slot.
  - A request with no free slot is dropped and sets overflow.
- Wake rules:
  - Reason 00: allocated directly into READY.
  - Reason 01: WAIT_DLY with counter=DELAY-1. The entry goes READY when the counter is 0.
  - Reason 10: WAIT_RFL with counter=MISS_TIMEOUT-1. The entry goes READY on refill_en or when the counter reaches 0.
  - refill_en in the allocation cycle allocates a reason-10 entry directly as READY.
- Selection: for each bank b, pick one READY entry with bank==b. Age priority is set by the configuration macro (see Configuration). The chosen entry returns to FREE the next cycle.
- Redirect:
  - In the redirect cycle, every valid entry strictly younger than redirectIdx becomes FREE. The comparison is wrap-aware using the dir bit.
  - Same-cycle requests younger than redirectIdx are not allocated.
  - No selection is made in that cycle, so rel_en is 0 in the following cycle.
- full and count derive only from registered state. They do not depend on same-cycle requests.

## Timing
- Reset values:
  - Outputs rel_en=0, rel_idx=0, full=0, count=0, overflow=0.
  - All entries FREE.
- Reason 00 request in cycle t: rel_en in t+2.
- Reason 01 request in cycle t: READY at t+DELAY, rel_en at t+DELAY+1.
- refill_en in cycle r: WAIT_RFL entries are READY at r+1, and rel_en for a selected entry is at r+2.
- Timeout: a reason-10 entry with no refill has rel_en at t+MISS_TIMEOUT+1.
- Release and allocation of the same slot in the same cycle: the slot is not FREE yet, so the allocator skips it.
- Reset mid-wait: all entries are discarded. overflow clears only on reset.

## Configuration
- LOAD_REPLAY_AGE_EN defined: per-bank selection picks the oldest READY entry by robIdx, using a wrap-aware compare tree.
- LOAD_REPLAY_AGE_EN undefined: per-bank selection picks the lowest-index READY entry. Timing is otherwise identical.

## Structure
- Shared package items:
  - ReplayReason constants: REPLAY_BANK_CONFLICT, REPLAY_STORE_DATA, REPLAY_DCACHE_MISS, REPLAY_TLB_MISS.
  - ReplayState enum.
  - ReplayEntry struct.
- Sub-module load_replay_select: one instance per bank, taking a READY mask and robIdx array and producing a one-hot select. The age mode is chosen by the configuration macro.

## Test plan
- Pipe 0 reason 00 with idx 3 at t=10: rel_en[0]=1 and rel_idx[0]=3 at t=12. The entry is FREE at t=13 and count returns to 0.
- Pipe 1 reason 01 with DELAY=4 at t=5: rel_en[1] at t=10, not earlier.
- Three reason-10 entries for bank 0, then refill_en at r: releases at r+2, r+3 and r+4, in age order with the macro defined and in slot order without it.
- Reason 10 with no refill and MISS_TIMEOUT=64, requested at t: rel_en at t+65.
- Fill to DEPTH-1 entries: full=1. Then force two requests: one is allocated, one is dropped, and overflow=1.
- Entries with robIdx {0,5}, {0,9} and {1,2}, then redirect with redirectIdx={0,6}:
  - Only {0,5} survives.
  - rel_en=0 in the cycle after the redirect.
  - The wrap case {1,2} is confirmed as younger and flushed.

Source files
------------

// File: rtl/load_replay_sched_pkg.sv
// Shared types for the load replay scheduler: replay reasons, entry state,
// entry record, ROB age tag and backend redirect control.
// Build-wide widths come from `LOAD_PIPELINE and `LOAD_ISSUE_BANK_WIDTH.
`ifndef LOAD_PIPELINE
`define LOAD_PIPELINE 2
`endif
`ifndef LOAD_ISSUE_BANK_WIDTH
`define LOAD_ISSUE_BANK_WIDTH 4
`endif

package load_replay_sched_pkg;

  localparam int LOAD_PIPELINE_N = `LOAD_PIPELINE;
  localparam int ISSUE_W         = `LOAD_ISSUE_BANK_WIDTH;
  localparam int ROB_IDX_W       = 6;
  localparam int BANK_W          = (LOAD_PIPELINE_N > 1) ? $clog2(LOAD_PIPELINE_N) : 1;

  typedef logic [1:0] ReplayReason;
  localparam ReplayReason REPLAY_BANK_CONFLICT = 2'b00;
  localparam ReplayReason REPLAY_STORE_DATA    = 2'b01;
  localparam ReplayReason REPLAY_DCACHE_MISS   = 2'b10;
  localparam ReplayReason REPLAY_TLB_MISS      = 2'b11;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    WAIT_DLY = 2'd1,
    WAIT_RFL = 2'd2,
    READY    = 2'd3
  } ReplayState;

  typedef struct packed {
    logic                 dir;
    logic [ROB_IDX_W-1:0] value;
  } RobIdx;

  typedef struct packed {
    logic  redirect;
    RobIdx redirectIdx;
  } BackendCtrl;

  typedef struct packed {
    logic               valid;
    logic [BANK_W-1:0]  bank;
    logic [ISSUE_W-1:0] issue_idx;
    RobIdx              robIdx;
    ReplayState         state;
    logic [7:0]         cnt;
  } ReplayEntry;

  // a is strictly younger than b; a differing dir bit means the index wrapped
  function automatic logic rob_younger(input RobIdx a, input RobIdx b);
    return (a.dir != b.dir) ? (a.value < b.value) : (a.value > b.value);
  endfunction

endpackage

// File: rtl/load_replay_sched_if.sv
// Request/release bundle between the load pipelines/issue banks and the
// replay scheduler. master = pipelines/banks side, slave = scheduler.
interface load_replay_sched_if
  import load_replay_sched_pkg::*;
#(
  parameter int PIPE  = LOAD_PIPELINE_N,
  parameter int DEPTH = 8
) ();

  logic [PIPE-1:0]              req_en;
  logic [PIPE-1:0][ISSUE_W-1:0] req_issue_idx;
  logic [PIPE-1:0][1:0]         req_reason;
  RobIdx [PIPE-1:0]             req_rob_idx;
  logic                         refill_en;
  BackendCtrl                   backendCtrl;
  logic [PIPE-1:0]              rel_en;
  logic [PIPE-1:0][ISSUE_W-1:0] rel_idx;
  logic                         full;
  logic [$clog2(DEPTH):0]       count;
  logic                         overflow;

  modport master (
    output req_en, req_issue_idx, req_reason, req_rob_idx, refill_en, backendCtrl,
    input  rel_en, rel_idx, full, count, overflow
  );

  modport slave (
    input  req_en, req_issue_idx, req_reason, req_rob_idx, refill_en, backendCtrl,
    output rel_en, rel_idx, full, count, overflow
  );

endinterface

// File: rtl/load_replay_select.sv
// Per-bank release picker: one-hot choice among READY entries.
// LOAD_REPLAY_AGE_EN defined: oldest by wrap-aware robIdx; otherwise lowest index.
module load_replay_select
  import load_replay_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] ready,
  input  RobIdx            rob [DEPTH],
  output logic [DEPTH-1:0] sel
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] idx;
    RobIdx         rob;
  } Cand;

`ifdef LOAD_REPLAY_AGE_EN
  function automatic logic left_wins(input Cand l, input Cand r);
    return l.v && (!r.v || !rob_younger(l.rob, r.rob));
  endfunction
`else
  function automatic logic left_wins(input Cand l, input Cand r);
    return l.v || !r.v;
  endfunction
`endif

  // Binary tournament tree in heap layout; ties go to the left (lower index)
  function automatic logic [DEPTH-1:0] pick(input logic [DEPTH-1:0] rdy, input RobIdx r [DEPTH]);
    Cand              node [2*DEPTH];
    logic [DEPTH-1:0] oh;
    int unsigned      n;
    for (int unsigned i = 0; i < 2 * DEPTH; i++) node[i] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      node[DEPTH+i].v   = rdy[i];
      node[DEPTH+i].idx = IW'(i);
      node[DEPTH+i].rob = r[i];
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      n = DEPTH - k;
      node[n] = left_wins(node[2*n], node[2*n+1]) ? node[2*n] : node[2*n+1];
    end
    oh = '0;
    if (node[1].v) oh[node[1].idx] = 1'b1;
    return oh;
  endfunction

  // Combinational winner for this bank
  always_comb sel = pick(ready, rob);

endmodule

// File: rtl/load_replay_sched.sv
// Load replay scheduler: pools non-TLB replay requests, wakes them after a
// delay or a D-cache refill/timeout, releases one per bank per cycle, and
// flushes entries younger than a redirect.
// Selection age mode: LOAD_REPLAY_AGE_EN (see load_replay_select).
module load_replay_sched
  import load_replay_sched_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int PIPE         = LOAD_PIPELINE_N,
  parameter int DELAY        = 4,
  parameter int MISS_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  load_replay_sched_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  ReplayEntry                   ent_q [DEPTH];
  ReplayEntry                   alloc_ent [DEPTH];
  RobIdx                        ent_rob [DEPTH];
  logic [DEPTH-1:0]             alloc_hit;
  logic                         drop, found;
  logic [DEPTH-1:0]             sel_q, sel_d;
  logic [DEPTH-1:0]             ready_mask [PIPE];
  logic [DEPTH-1:0]             sel_oh [PIPE];
  logic [PIPE-1:0]              rel_en_q, rel_en_d;
  logic [PIPE-1:0][ISSUE_W-1:0] rel_idx_q, rel_idx_d;
  logic                         overflow_q;
  logic [CW-1:0]                count_c;
  logic                         redirect;
  RobIdx                        redirect_idx;

  assign redirect     = bus.backendCtrl.redirect;
  assign redirect_idx = bus.backendCtrl.redirectIdx;

  function automatic ReplayEntry new_entry(input logic [BANK_W-1:0] bank,
                                           input logic [ISSUE_W-1:0] idx,
                                           input ReplayReason rsn,
                                           input RobIdx rob, input logic refill);
    ReplayEntry e;
    e           = '0;
    e.valid     = 1'b1;
    e.bank      = bank;
    e.issue_idx = idx;
    e.robIdx    = rob;
    e.state     = READY;
    if (rsn == REPLAY_STORE_DATA && DELAY > 1) begin
      e.state = WAIT_DLY;
      e.cnt   = 8'(DELAY - 1);
    end else if (rsn == REPLAY_DCACHE_MISS && !refill) begin
      e.state = WAIT_RFL;
      e.cnt   = 8'(MISS_TIMEOUT - 1);
    end
    return e;
  endfunction

  // Allocation: pipes in order each claim the lowest still-unclaimed FREE slot
  always_comb begin
    alloc_hit = '0;
    drop      = 1'b0;
    found     = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) alloc_ent[i] = '0;
    for (int unsigned p = 0; p < PIPE; p++) begin
      found = 1'b0;
      if (bus.req_en[p] && bus.req_reason[p] != REPLAY_TLB_MISS &&
          !(redirect && rob_younger(bus.req_rob_idx[p], redirect_idx))) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!found && ent_q[i].state == FREE && !alloc_hit[i]) begin
            found        = 1'b1;
            alloc_hit[i] = 1'b1;
            alloc_ent[i] = new_entry(BANK_W'(p), bus.req_issue_idx[p], bus.req_reason[p],
                                     bus.req_rob_idx[p], bus.refill_en);
          end
        end
        if (!found) drop = 1'b1;
      end
    end
  end

  // Per-bank candidates; an entry already being released is still occupied
  // this cycle (freed on the next edge) so it is masked out of selection.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) ent_rob[i] = ent_q[i].robIdx;
    for (int unsigned b = 0; b < PIPE; b++)
      for (int unsigned i = 0; i < DEPTH; i++)
        ready_mask[b][i] = ent_q[i].state == READY && ent_q[i].bank == BANK_W'(b) && !sel_q[i];
  end

  for (genvar b = 0; b < PIPE; b++) begin : g_sel
    load_replay_select #(.DEPTH(DEPTH)) u_sel (
      .ready (ready_mask[b]),
      .rob   (ent_rob),
      .sel   (sel_oh[b])
    );
  end

  // Next release set; suppressed entirely in a redirect cycle
  always_comb begin
    sel_d     = '0;
    rel_en_d  = '0;
    rel_idx_d = '0;
    if (!redirect) begin
      for (int unsigned b = 0; b < PIPE; b++) begin
        sel_d       = sel_d | sel_oh[b];
        rel_en_d[b] = |sel_oh[b];
        for (int unsigned i = 0; i < DEPTH; i++)
          if (sel_oh[b][i]) rel_idx_d[b] = ent_q[i].issue_idx;
      end
    end
  end

  // Entry FSMs, release registers and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      sel_q      <= '0;
      rel_en_q   <= '0;
      rel_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      rel_en_q  <= rel_en_d;
      rel_idx_q <= rel_idx_d;
      if (drop) overflow_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_hit[i]) begin
          ent_q[i] <= alloc_ent[i];
        end else if (sel_q[i] ||
                     (ent_q[i].valid && redirect && rob_younger(ent_q[i].robIdx, redirect_idx))) begin
          ent_q[i] <= '0;
        end else begin
          case (ent_q[i].state)
            WAIT_DLY: begin
              if (ent_q[i].cnt <= 8'd1) begin
                ent_q[i].state <= READY;
                ent_q[i].cnt   <= '0;
              end else begin
                ent_q[i].cnt <= ent_q[i].cnt - 8'd1;
              end
            end
            WAIT_RFL: begin
              if (bus.refill_en || ent_q[i].cnt <= 8'd1) begin
                ent_q[i].state <= READY;
                ent_q[i].cnt   <= '0;
              end else begin
                ent_q[i].cnt <= ent_q[i].cnt - 8'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Occupancy from registered entry state only
  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (ent_q[i].valid) count_c = count_c + CW'(1);
  end

  assign bus.rel_en   = rel_en_q;
  assign bus.rel_idx  = rel_idx_q;
  assign bus.count    = count_c;
  assign bus.full     = count_c > CW'(DEPTH - PIPE);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_load_replay_sched.sv
// Directed bench for load_replay_sched (DEPTH=8, PIPE=2, DELAY=4, MISS_TIMEOUT=64).
module tb_load_replay_sched;
  import load_replay_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  load_replay_sched_if #(.PIPE(2), .DEPTH(8)) bus ();

  load_replay_sched #(.DEPTH(8), .PIPE(2), .DELAY(4), .MISS_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic RobIdx mk_rob(input logic d, input logic [5:0] v);
    RobIdx r;
    r.dir   = d;
    r.value = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_en        = '0;
    bus.req_issue_idx = '0;
    bus.req_reason    = '0;
    bus.req_rob_idx   = '0;
    bus.refill_en     = 1'b0;
    bus.backendCtrl   = '0;
  endtask

  task automatic drive(input int p, input logic [3:0] idx, input logic [1:0] rsn,
                       input logic d, input logic [5:0] v);
    bus.req_en[p]        = 1'b1;
    bus.req_issue_idx[p] = idx;
    bus.req_reason[p]    = rsn;
    bus.req_rob_idx[p]   = mk_rob(d, v);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL rst_rel_en: got %b want 00", bus.rel_en); end
    n_cmp++; if (bus.rel_idx !== 8'h00) begin n_bad++; $display("FAIL rst_rel_idx: got %h want 00", bus.rel_idx); end
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bank_conflict();
    drive(0, 4'd3, 2'b00, 1'b0, 6'd1);
    tick(); clear_reqs();
    n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("FAIL bc_count_t1: got %0d want 1", bus.count); end
    n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL bc_early_rel: got %b want 00", bus.rel_en); end
    tick();
    n_cmp++; if (bus.rel_en !== 2'b01) begin n_bad++; $display("FAIL bc_rel_en_t2: got %b want 01", bus.rel_en); end
    n_cmp++; if (bus.rel_idx[0] !== 4'd3) begin n_bad++; $display("FAIL bc_rel_idx_t2: got %0d want 3", bus.rel_idx[0]); end
    n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("FAIL bc_count_t2: got %0d want 1", bus.count); end
    tick();
    n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL bc_rel_once: got %b want 00", bus.rel_en); end
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL bc_count_t3: got %0d want 0", bus.count); end
  endtask

  task automatic test_store_data();
    drive(1, 4'd9, 2'b01, 1'b0, 6'd2);
    tick(); clear_reqs();
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL sd_early_t%0d: got %b want 00", k, bus.rel_en); end
      tick();
    end
    n_cmp++; if (bus.rel_en !== 2'b10) begin n_bad++; $display("FAIL sd_rel_en_t5: got %b want 10", bus.rel_en); end
    n_cmp++; if (bus.rel_idx[1] !== 4'd9) begin n_bad++; $display("FAIL sd_rel_idx_t5: got %0d want 9", bus.rel_idx[1]); end
    tick();
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL sd_count_t6: got %0d want 0", bus.count); end
  endtask

  task automatic test_back_to_back();
    drive(0, 4'd2, 2'b00, 1'b0, 6'd3);
    drive(1, 4'd13, 2'b00, 1'b0, 6'd4);
    tick(); clear_reqs();
    n_cmp++; if (bus.count !== 4'd2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", bus.count); end
    tick();
    n_cmp++; if (bus.rel_en !== 2'b11) begin n_bad++; $display("FAIL b2b_rel_en: got %b want 11", bus.rel_en); end
    n_cmp++; if (bus.rel_idx !== {4'd13, 4'd2}) begin n_bad++; $display("FAIL b2b_rel_idx: got %h want d2", bus.rel_idx); end
    tick();
  endtask

  task automatic test_refill_order();
    logic [3:0] exp_ord [3];
`ifdef LOAD_REPLAY_AGE_EN
    exp_ord = '{4'd6, 4'd5, 4'd7};
`else
    exp_ord = '{4'd5, 4'd6, 4'd7};
`endif
    do_reset();
    drive(0, 4'd5, 2'b10, 1'b0, 6'd20); tick();
    drive(0, 4'd6, 2'b10, 1'b0, 6'd10); tick();
    drive(0, 4'd7, 2'b10, 1'b0, 6'd30); tick();
    clear_reqs();
    bus.refill_en = 1'b1;
    n_cmp++; if (bus.count !== 4'd3) begin n_bad++; $display("FAIL rf_count: got %0d want 3", bus.count); end
    tick(); clear_reqs();
    n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL rf_early_r1: got %b want 00", bus.rel_en); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (bus.rel_en !== 2'b01) begin n_bad++; $display("FAIL rf_rel_en_%0d: got %b want 01", k, bus.rel_en); end
      n_cmp++; if (bus.rel_idx[0] !== exp_ord[k]) begin n_bad++; $display("FAIL rf_order_%0d: got %0d want %0d", k, bus.rel_idx[0], exp_ord[k]); end
    end
    tick();
    n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL rf_done_rel: got %b want 00", bus.rel_en); end
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL rf_done_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_refill_same_cycle();
    drive(0, 4'd10, 2'b10, 1'b0, 6'd4);
    bus.refill_en = 1'b1;
    tick(); clear_reqs();
    n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL rs_early: got %b want 00", bus.rel_en); end
    tick();
    n_cmp++; if (bus.rel_en !== 2'b01) begin n_bad++; $display("FAIL rs_rel_en: got %b want 01", bus.rel_en); end
    n_cmp++; if (bus.rel_idx[0] !== 4'd10) begin n_bad++; $display("FAIL rs_rel_idx: got %0d want 10", bus.rel_idx[0]); end
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    drive(0, 4'd4, 2'b10, 1'b0, 6'd3);
    tick(); clear_reqs();
    cyc = 1;
    while (bus.rel_en[0] !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    n_cmp++; if (cyc != 65) begin n_bad++; $display("FAIL to_latency: got %0d want 65", cyc); end
    n_cmp++; if (bus.rel_idx[0] !== 4'd4) begin n_bad++; $display("FAIL to_rel_idx: got %0d want 4", bus.rel_idx[0]); end
    tick();
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'(k), 2'b10, 1'b0, 6'(k));
      drive(1, 4'(k + 8), 2'b10, 1'b0, 6'(k + 8));
      tick();
    end
    clear_reqs();
    n_cmp++; if (bus.count !== 4'd6) begin n_bad++; $display("FAIL fo_count6: got %0d want 6", bus.count); end
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL fo_full6: got %b want 0", bus.full); end
    drive(0, 4'd3, 2'b10, 1'b0, 6'd3);
    tick(); clear_reqs();
    n_cmp++; if (bus.count !== 4'd7) begin n_bad++; $display("FAIL fo_count7: got %0d want 7", bus.count); end
    n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL fo_full7: got %b want 1", bus.full); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL fo_ovf_pre: got %b want 0", bus.overflow); end
    drive(0, 4'd4, 2'b10, 1'b0, 6'd4);
    drive(1, 4'd12, 2'b10, 1'b0, 6'd12);
    tick(); clear_reqs();
    n_cmp++; if (bus.count !== 4'd8) begin n_bad++; $display("FAIL fo_count8: got %0d want 8", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL fo_ovf_set: got %b want 1", bus.overflow); end
    tick();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL fo_ovf_sticky: got %b want 1", bus.overflow); end
  endtask

  task automatic test_reset_mid_wait();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL rm_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rm_overflow: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL rm_full: got %b want 0", bus.full); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL rm_count_after: got %0d want 0", bus.count); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(0, 4'd1, 2'b10, 1'b0, 6'd9);
    drive(1, 4'd2, 2'b10, 1'b1, 6'd2);
    tick(); clear_reqs();
    drive(0, 4'd11, 2'b00, 1'b0, 6'd5);
    tick(); clear_reqs();
    n_cmp++; if (bus.count !== 4'd3) begin n_bad++; $display("FAIL rd_count_pre: got %0d want 3", bus.count); end
    bus.backendCtrl.redirect    = 1'b1;
    bus.backendCtrl.redirectIdx = mk_rob(1'b0, 6'd6);
    drive(1, 4'd12, 2'b00, 1'b0, 6'd7);
    tick(); clear_reqs();
    n_cmp++; if (bus.rel_en !== 2'b00) begin n_bad++; $display("FAIL rd_no_rel: got %b want 00", bus.rel_en); end
    n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("FAIL rd_survivors: got %0d want 1", bus.count); end
    tick();
    n_cmp++; if (bus.rel_en !== 2'b01) begin n_bad++; $display("FAIL rd_rel_en_after: got %b want 01", bus.rel_en); end
    n_cmp++; if (bus.rel_idx[0] !== 4'd11) begin n_bad++; $display("FAIL rd_rel_idx_after: got %0d want 11", bus.rel_idx[0]); end
    tick();
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL rd_count_end: got %0d want 0", bus.count); end
  endtask

  initial begin
    test_reset();
    test_bank_conflict();
    test_store_data();
    test_back_to_back();
    test_refill_order();
    test_refill_same_cycle();
    test_timeout();
    test_fill_overflow();
    test_reset_mid_wait();
    test_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
